// File: rtl/mips_alu_pcsel.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_pcsel
// Brief    : MIPS ALU with control decoder, HI/LO multiply/divide results,
//            next-PC target selection and a registered copy of the target.
// Revision : 1.0 - initial release
// ============================================================================
module mips_alu_pcsel (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  opcode,
    input  logic [5:0]  function_code,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  shamt,
    output logic [4:0]  alu_ctrl_in,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic [31:0] pc_plus4,
    input  logic        condition_met,
    input  logic        jump1,
    input  logic        jump2,
    output logic [31:0] tgt_addr_0,
    output logic [31:0] tgt_addr_1
);

    // Internal ALU operation codes
    localparam logic [4:0] c_ADD   = 5'd0;
    localparam logic [4:0] c_SUB   = 5'd1;
    localparam logic [4:0] c_AND   = 5'd2;
    localparam logic [4:0] c_OR    = 5'd3;
    localparam logic [4:0] c_XOR   = 5'd4;
    localparam logic [4:0] c_NOR   = 5'd5;
    localparam logic [4:0] c_SLT   = 5'd6;
    localparam logic [4:0] c_SLTU  = 5'd7;
    localparam logic [4:0] c_SLL   = 5'd8;
    localparam logic [4:0] c_SRL   = 5'd9;
    localparam logic [4:0] c_SRA   = 5'd10;
    localparam logic [4:0] c_SLLV  = 5'd11;
    localparam logic [4:0] c_SRLV  = 5'd12;
    localparam logic [4:0] c_SRAV  = 5'd13;
    localparam logic [4:0] c_MULT  = 5'd14;
    localparam logic [4:0] c_MULTU = 5'd15;
    localparam logic [4:0] c_DIV   = 5'd16;
    localparam logic [4:0] c_DIVU  = 5'd17;
    localparam logic [4:0] c_LUI   = 5'd18;

    logic [4:0]         w_ctrl;
    logic [31:0]        w_alu_out;
    logic [31:0]        w_hi;
    logic [31:0]        w_lo;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_tgt;
    logic [31:0]        r_tgt_addr_1;

    // Full 64-bit products; operands are explicitly extended to 64 bits
    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'h0, A} * {32'h0, B};

    // Decode alu_op / funct / opcode into the internal operation code
    always_comb begin
        w_ctrl = c_ADD;
        case (alu_op)
            2'b00: w_ctrl = c_ADD;
            2'b01: w_ctrl = c_SUB;
            2'b10: begin
                case (function_code)
                    6'h00:   w_ctrl = c_SLL;
                    6'h02:   w_ctrl = c_SRL;
                    6'h03:   w_ctrl = c_SRA;
                    6'h04:   w_ctrl = c_SLLV;
                    6'h06:   w_ctrl = c_SRLV;
                    6'h07:   w_ctrl = c_SRAV;
                    6'h18:   w_ctrl = c_MULT;
                    6'h19:   w_ctrl = c_MULTU;
                    6'h1A:   w_ctrl = c_DIV;
                    6'h1B:   w_ctrl = c_DIVU;
                    6'h21:   w_ctrl = c_ADD;
                    6'h23:   w_ctrl = c_SUB;
                    6'h24:   w_ctrl = c_AND;
                    6'h25:   w_ctrl = c_OR;
                    6'h26:   w_ctrl = c_XOR;
                    6'h27:   w_ctrl = c_NOR;
                    6'h2A:   w_ctrl = c_SLT;
                    6'h2B:   w_ctrl = c_SLTU;
                    // JR, JALR, HI/LO moves and undefined codes use the adder
                    default: w_ctrl = c_ADD;
                endcase
            end
            default: begin
                case (opcode)
                    6'h09:   w_ctrl = c_ADD;
                    6'h0A:   w_ctrl = c_SLT;
                    6'h0B:   w_ctrl = c_SLTU;
                    6'h0C:   w_ctrl = c_AND;
                    6'h0D:   w_ctrl = c_OR;
                    6'h0E:   w_ctrl = c_XOR;
                    6'h0F:   w_ctrl = c_LUI;
                    default: w_ctrl = c_ADD;
                endcase
            end
        endcase
    end

    // Execute the decoded operation; HI/LO are only non-zero for mult/div
    always_comb begin
        w_alu_out = 32'h0;
        w_hi      = 32'h0;
        w_lo      = 32'h0;
        case (w_ctrl)
            c_ADD:  w_alu_out = A + B;
            c_SUB:  w_alu_out = A - B;
            c_AND:  w_alu_out = A & B;
            c_OR:   w_alu_out = A | B;
            c_XOR:  w_alu_out = A ^ B;
            c_NOR:  w_alu_out = ~(A | B);
            c_SLT:  w_alu_out = {31'h0, ($signed(A) < $signed(B))};
            c_SLTU: w_alu_out = {31'h0, (A < B)};
            c_SLL:  w_alu_out = B << shamt;
            c_SRL:  w_alu_out = B >> shamt;
            c_SRA:  w_alu_out = $signed(B) >>> shamt;
            c_SLLV: w_alu_out = B << A[4:0];
            c_SRLV: w_alu_out = B >> A[4:0];
            c_SRAV: w_alu_out = $signed(B) >>> A[4:0];
            c_MULT: begin
                w_hi = w_prod_s[63:32];
                w_lo = w_prod_s[31:0];
            end
            c_MULTU: begin
                w_hi = w_prod_u[63:32];
                w_lo = w_prod_u[31:0];
            end
            c_DIV: begin
                // Divide by zero leaves HI/LO at zero rather than trapping
                if (B != 32'h0) begin
                    w_lo = $signed(A) / $signed(B);
                    w_hi = $signed(A) % $signed(B);
                end
            end
            c_DIVU: begin
                if (B != 32'h0) begin
                    w_lo = A / B;
                    w_hi = A % B;
                end
            end
            c_LUI:  w_alu_out = {B[15:0], 16'h0000};
            default: w_alu_out = A + B;
        endcase
    end

    // Next-PC target: register jump beats direct jump beats taken branch
    always_comb begin
        w_tgt = pc_plus4;
        if (jump2)
            w_tgt = A;
        else if (jump1)
            w_tgt = jump_addr;
        else if (condition_met)
            w_tgt = branch_addr;
    end

    // Registered copy of the target, gated by clk_enable, cleared by reset
    always_ff @(posedge clk) begin
        if (reset)
            r_tgt_addr_1 <= 32'h0;
        else if (clk_enable)
            r_tgt_addr_1 <= w_tgt;
    end

    assign alu_ctrl_in = w_ctrl;
    assign alu_out     = w_alu_out;
    assign zero        = (w_alu_out == 32'h0);
    assign hi          = w_hi;
    assign lo          = w_lo;
    assign tgt_addr_0  = w_tgt;
    assign tgt_addr_1  = r_tgt_addr_1;

endmodule
`default_nettype wire

// File: tb/tb_mips_alu_pcsel.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_alu_pcsel
// Brief    : Scoreboard bench for mips_alu_pcsel with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_alu_pcsel;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  opcode = 6'h0;
    logic [5:0]  function_code = 6'h0;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic [4:0]  shamt = 5'h0;
    logic [4:0]  alu_ctrl_in;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] branch_addr = 32'h0;
    logic [31:0] jump_addr = 32'h0;
    logic [31:0] pc_plus4 = 32'h0;
    logic        condition_met = 1'b0;
    logic        jump1 = 1'b0;
    logic        jump2 = 1'b0;
    logic [31:0] tgt_addr_0;
    logic [31:0] tgt_addr_1;

    mips_alu_pcsel dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .alu_op        (alu_op),
        .opcode        (opcode),
        .function_code (function_code),
        .A             (A),
        .B             (B),
        .shamt         (shamt),
        .alu_ctrl_in   (alu_ctrl_in),
        .alu_out       (alu_out),
        .zero          (zero),
        .hi            (hi),
        .lo            (lo),
        .branch_addr   (branch_addr),
        .jump_addr     (jump_addr),
        .pc_plus4      (pc_plus4),
        .condition_met (condition_met),
        .jump1         (jump1),
        .jump2         (jump2),
        .tgt_addr_0    (tgt_addr_0),
        .tgt_addr_1    (tgt_addr_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_alu;
        bit          chk_t0;
        bit          chk_t1;
        logic [4:0]  ctrl;
        logic [31:0] out;
        logic        z;
        logic [31:0] hv;
        logic [31:0] lv;
        logic [31:0] t0;
        logic [31:0] t1;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, req);
        end
    endfunction

    // Monitor: outputs are stable by the falling edge; compare queued expectations
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk_alu) begin
                check({e.name, ".ctrl"}, {27'h0, alu_ctrl_in}, {27'h0, e.ctrl});
                check({e.name, ".out"},  alu_out, e.out);
                check({e.name, ".zero"}, {31'h0, zero}, {31'h0, e.z});
                check({e.name, ".hi"},   hi, e.hv);
                check({e.name, ".lo"},   lo, e.lv);
            end
            if (e.chk_t0) check({e.name, ".tgt0"}, tgt_addr_0, e.t0);
            if (e.chk_t1) check({e.name, ".tgt1"}, tgt_addr_1, e.t1);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string nm, input logic [1:0] op, input logic [5:0] opc,
                           input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [4:0] ec, input logic [31:0] eo,
                           input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        step;
        alu_op = op; opcode = opc; function_code = fn; A = a; B = b; shamt = sh;
        e = '{name: nm, chk_alu: 1'b1, chk_t0: 1'b0, chk_t1: 1'b0, ctrl: ec, out: eo,
              z: (eo == 32'h0), hv: ehi, lv: elo, t0: 32'h0, t1: 32'h0};
        q.push_back(e);
    endtask

    task automatic sel_vec(input string nm, input logic j2, input logic j1, input logic cm,
                           input logic [31:0] a, input logic [31:0] et0);
        exp_t e;
        step;
        jump2 = j2; jump1 = j1; condition_met = cm; A = a;
        e = '{name: nm, chk_alu: 1'b0, chk_t0: 1'b1, chk_t1: 1'b0, ctrl: 5'h0, out: 32'h0,
              z: 1'b0, hv: 32'h0, lv: 32'h0, t0: et0, t1: 32'h0};
        q.push_back(e);
    endtask

    task automatic reg_vec(input string nm, input logic rs, input logic en,
                           input logic [31:0] et0, input logic [31:0] et1);
        exp_t e;
        step;
        reset = rs; clk_enable = en;
        e = '{name: nm, chk_alu: 1'b0, chk_t0: 1'b1, chk_t1: 1'b1, ctrl: 5'h0, out: 32'h0,
              z: 1'b0, hv: 32'h0, lv: 32'h0, t0: et0, t1: et1};
        q.push_back(e);
    endtask

    initial begin
        int budget;
        // Reset state: tgt_addr_1 cleared, combinational paths live during reset
        step; step;
        reg_vec("rst_state", 1'b1, 1'b0, 32'h0, 32'h0);
        alu_vec("add_in_rst", 2'b10, 6'h00, 6'h21, 32'hFFFFFFFF, 32'h1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        step; reset = 1'b0;

        // ALU vectors
        alu_vec("sra",      2'b10, 6'h00, 6'h03, 32'h0,        32'h80000000, 5'd4,  5'd10, 32'hF8000000, 32'h0, 32'h0);
        alu_vec("srav",     2'b10, 6'h00, 6'h07, 32'h24,       32'h80000000, 5'd0,  5'd13, 32'hF8000000, 32'h0, 32'h0);
        alu_vec("mult",     2'b10, 6'h00, 6'h18, 32'hFFFFFFFE, 32'h3,        5'd0,  5'd14, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        alu_vec("div",      2'b10, 6'h00, 6'h1A, 32'hFFFFFFF9, 32'h2,        5'd0,  5'd16, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        alu_vec("div0",     2'b10, 6'h00, 6'h1A, 32'hFFFFFFF9, 32'h0,        5'd0,  5'd16, 32'h0, 32'h0, 32'h0);
        alu_vec("divu0",    2'b10, 6'h00, 6'h1B, 32'h12345678, 32'h0,        5'd0,  5'd17, 32'h0, 32'h0, 32'h0);
        alu_vec("multu",    2'b10, 6'h00, 6'h19, 32'hFFFFFFFF, 32'h2,        5'd0,  5'd15, 32'h0, 32'h1, 32'hFFFFFFFE);
        alu_vec("divu",     2'b10, 6'h00, 6'h1B, 32'hFFFFFFF9, 32'h2,        5'd0,  5'd17, 32'h0, 32'h1, 32'h7FFFFFFC);
        alu_vec("lui",      2'b11, 6'h0F, 6'h00, 32'h0,        32'h00001234, 5'd0,  5'd18, 32'h12340000, 32'h0, 32'h0);
        alu_vec("sltiu",    2'b11, 6'h0B, 6'h00, 32'hFFFFFFFF, 32'h1,        5'd0,  5'd7,  32'h0, 32'h0, 32'h0);
        alu_vec("slti",     2'b11, 6'h0A, 6'h00, 32'hFFFFFFFF, 32'h1,        5'd0,  5'd6,  32'h1, 32'h0, 32'h0);
        alu_vec("xori",     2'b11, 6'h0E, 6'h00, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0,  5'd4,  32'hF00FF00F, 32'h0, 32'h0);
        alu_vec("ori",      2'b11, 6'h0D, 6'h00, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0,  5'd3,  32'hFF0FFF0F, 32'h0, 32'h0);
        alu_vec("beq_add",  2'b11, 6'h04, 6'h00, 32'h5,        32'h7,        5'd0,  5'd0,  32'hC, 32'h0, 32'h0);
        alu_vec("op00",     2'b00, 6'h0A, 6'h23, 32'h5,        32'h7,        5'd0,  5'd0,  32'hC, 32'h0, 32'h0);
        alu_vec("op01",     2'b01, 6'h0F, 6'h18, 32'h5,        32'h7,        5'd0,  5'd1,  32'hFFFFFFFE, 32'h0, 32'h0);
        alu_vec("sub_eq",   2'b10, 6'h00, 6'h23, 32'h12345678, 32'h12345678, 5'd0,  5'd1,  32'h0, 32'h0, 32'h0);
        alu_vec("and",      2'b10, 6'h00, 6'h24, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0,  5'd2,  32'h0F000F00, 32'h0, 32'h0);
        alu_vec("nor",      2'b10, 6'h00, 6'h27, 32'h0,        32'h0,        5'd0,  5'd5,  32'hFFFFFFFF, 32'h0, 32'h0);
        alu_vec("sll",      2'b10, 6'h00, 6'h00, 32'h0,        32'h1,        5'd31, 5'd8,  32'h80000000, 32'h0, 32'h0);
        alu_vec("srl",      2'b10, 6'h00, 6'h02, 32'h0,        32'h80000000, 5'd4,  5'd9,  32'h08000000, 32'h0, 32'h0);
        alu_vec("sllv",     2'b10, 6'h00, 6'h04, 32'h3,        32'h1,        5'd0,  5'd11, 32'h8, 32'h0, 32'h0);
        alu_vec("srlv",     2'b10, 6'h00, 6'h06, 32'hFFFFFFE4, 32'hF0000000, 5'd0,  5'd12, 32'h0F000000, 32'h0, 32'h0);
        alu_vec("slt_neg",  2'b10, 6'h00, 6'h2A, 32'h80000000, 32'h1,        5'd0,  5'd6,  32'h1, 32'h0, 32'h0);
        alu_vec("sltu_big", 2'b10, 6'h00, 6'h2B, 32'h80000000, 32'h1,        5'd0,  5'd7,  32'h0, 32'h0, 32'h0);
        alu_vec("jr_add",   2'b10, 6'h00, 6'h08, 32'h1,        32'h2,        5'd0,  5'd0,  32'h3, 32'h0, 32'h0);

        // Target selection priority
        branch_addr = 32'h00400200; jump_addr = 32'hBFC00100; pc_plus4 = 32'hBFC00004;
        sel_vec("sel_j2",   1'b1, 1'b1, 1'b1, 32'h00400010, 32'h00400010);
        sel_vec("sel_none", 1'b0, 1'b0, 1'b0, 32'h00400010, 32'hBFC00004);
        sel_vec("sel_br",   1'b0, 1'b0, 1'b1, 32'h00400010, 32'h00400200);
        sel_vec("sel_j1cm", 1'b0, 1'b1, 1'b1, 32'h00400010, 32'hBFC00100);
        sel_vec("sel_j1",   1'b0, 1'b1, 1'b0, 32'h00400010, 32'hBFC00100);

        // Registered target: load, hold, reset
        reg_vec("ld_setup", 1'b0, 1'b1, 32'hBFC00100, 32'h0);
        step; jump1 = 1'b0; clk_enable = 1'b0;
        begin
            exp_t e;
            e = '{name: "ld", chk_alu: 1'b0, chk_t0: 1'b1, chk_t1: 1'b1, ctrl: 5'h0, out: 32'h0,
                  z: 1'b0, hv: 32'h0, lv: 32'h0, t0: 32'hBFC00004, t1: 32'hBFC00100};
            q.push_back(e);
        end
        reg_vec("hold",     1'b0, 1'b0, 32'hBFC00004, 32'hBFC00100);
        reg_vec("rst_pend", 1'b1, 1'b1, 32'hBFC00004, 32'hBFC00100);
        reg_vec("rst_done", 1'b0, 1'b0, 32'hBFC00004, 32'h0);
        reg_vec("reload",   1'b0, 1'b1, 32'hBFC00004, 32'h0);
        reg_vec("reloaded", 1'b0, 1'b0, 32'hBFC00004, 32'hBFC00004);

        // Drain the scoreboard with a bounded wait
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        check("drain", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
